// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS32 program loader.
// Checksum support is enabled by defining LOADER_CKSUM_EN.
package mips_loader_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_ADDR_HI = 4'd1,
      ST_ADDR_LO = 4'd2,
      ST_CNT_HI  = 4'd3,
      ST_CNT_LO  = 4'd4,
      ST_DATA    = 4'd5,
      ST_CHECK   = 4'd6,
      ST_START   = 4'd7,
      ST_RUN     = 4'd8,
      ST_ERR     = 4'd9
   } state_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   // Byte offsets of the frame header fields, counted from the sync byte
   localparam int unsigned HDR_OFF_SYNC    = 32'd0;
   localparam int unsigned HDR_OFF_ADDR_HI = 32'd1;
   localparam int unsigned HDR_OFF_ADDR_LO = 32'd2;
   localparam int unsigned HDR_OFF_CNT_HI  = 32'd3;
   localparam int unsigned HDR_OFF_CNT_LO  = 32'd4;
   localparam int unsigned HDR_LEN         = 32'd5;

   // Largest legal word count: one full pass over the address space
   function automatic logic [16:0] cnt_limit(input int unsigned aw);
      cnt_limit = 17'd1 << aw;
   endfunction

   function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] b);
      xor_acc = acc ^ b;
   endfunction

endpackage

// File: rtl/mips_word_assembler.sv
// Big-endian byte-to-word assembler with optional running XOR checksum.
// The checksum accumulator exists only when LOADER_CKSUM_EN is defined.
module mips_word_assembler
   import mips_loader_pkg::*;
(
   input  logic        clk1,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word
`ifdef LOADER_CKSUM_EN
   ,
   output logic [7:0]  cksum
`endif
);

   logic [1:0]  byte_cnt_r;
   logic [23:0] shift_r;

   // Word completes combinationally with its 4th byte; the caller registers it
   assign word_valid = byte_valid && (byte_cnt_r == 2'd3);
   assign word       = {shift_r, byte_data};

   // Shift register and byte counter, restarted at each frame
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         byte_cnt_r <= 2'd0;
         shift_r    <= 24'd0;
      end else if (clr) begin
         byte_cnt_r <= 2'd0;
         shift_r    <= 24'd0;
      end else if (byte_valid) begin
         byte_cnt_r <= byte_cnt_r + 2'd1;
         shift_r    <= word[23:0];
      end
   end

`ifdef LOADER_CKSUM_EN
   logic [7:0] cksum_r;

   assign cksum = cksum_r;

   // Running XOR over data bytes only
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         cksum_r <= 8'd0;
      end else if (clr) begin
         cksum_r <= 8'd0;
      end else if (byte_valid) begin
         cksum_r <= xor_acc(cksum_r, byte_data);
      end
   end
`endif

endmodule

// File: rtl/mips_prog_loader.sv
// Framed byte-stream program loader: writes core memory, then starts/monitors the core.
// Defining LOADER_CKSUM_EN adds a trailing XOR checksum byte to every frame.
module mips_prog_loader
   import mips_loader_pkg::*;
#(
   parameter int         ADDR_W    = 10,
   parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
)
(
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              core_start,
   input  logic              core_halted,
   output logic              load_done,
   output logic              load_err,
   output logic [15:0]       word_cnt
);

   localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

   state_t              state_r;
   logic [7:0]          addr_hi_r;
   logic [7:0]          cnt_hi_r;
   logic [15:0]         base_r;
   logic [15:0]         cnt_r;
   logic [ADDR_W-1:0]   idx_r;
   logic                run_first_r;

   logic                in_ready_r;
   logic                mem_we_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [31:0]         mem_wdata_r;
   logic                core_hold_r;
   logic                core_start_r;
   logic                load_done_r;
   logic                load_err_r;
   logic [15:0]         word_cnt_r;

   logic                accept_s;
   logic                is_sync_s;
   logic                frame_clr_s;
   logic                byte_valid_s;
   logic                word_valid_s;
   logic [31:0]         word_s;
   logic [15:0]         cnt_full_s;
   logic                last_word_s;
`ifdef LOADER_CKSUM_EN
   logic [7:0]          cksum_s;
`endif

   assign accept_s     = in_valid && in_ready_r;
   assign is_sync_s    = (in_data == SYNC_BYTE);
   assign frame_clr_s  = accept_s && is_sync_s && ((state_r == ST_IDLE) || (state_r == ST_ERR));
   assign byte_valid_s = accept_s && (state_r == ST_DATA);
   assign cnt_full_s   = {cnt_hi_r, in_data};
   assign last_word_s  = ((word_cnt_r + 16'd1) == cnt_r);

   mips_word_assembler u_asm (
      .clk1       (clk1),
      .rst_n      (rst_n),
      .clr        (frame_clr_s),
      .byte_valid (byte_valid_s),
      .byte_data  (in_data),
      .word_valid (word_valid_s),
      .word       (word_s)
`ifdef LOADER_CKSUM_EN
      ,
      .cksum      (cksum_s)
`endif
   );

   assign in_ready   = in_ready_r;
   assign mem_we     = mem_we_r;
   assign mem_addr   = mem_addr_r;
   assign mem_wdata  = mem_wdata_r;
   assign core_hold  = core_hold_r;
   assign core_start = core_start_r;
   assign load_done  = load_done_r;
   assign load_err   = load_err_r;
   assign word_cnt   = word_cnt_r;

   // Loader FSM with all outputs registered
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         addr_hi_r    <= 8'd0;
         cnt_hi_r     <= 8'd0;
         base_r       <= 16'd0;
         cnt_r        <= 16'd0;
         idx_r        <= '0;
         run_first_r  <= 1'b0;
         in_ready_r   <= 1'b1;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= '0;
         mem_wdata_r  <= 32'd0;
         core_hold_r  <= 1'b1;
         core_start_r <= 1'b0;
         load_done_r  <= 1'b0;
         load_err_r   <= 1'b0;
         word_cnt_r   <= 16'd0;
      end else begin
         mem_we_r     <= 1'b0;
         core_start_r <= 1'b0;
         case (state_r)
            ST_IDLE, ST_ERR: begin
               if (frame_clr_s) begin
                  state_r     <= ST_ADDR_HI;
                  load_done_r <= 1'b0;
                  load_err_r  <= 1'b0;
                  word_cnt_r  <= 16'd0;
               end
            end
            ST_ADDR_HI: begin
               if (accept_s) begin
                  addr_hi_r <= in_data;
                  state_r   <= ST_ADDR_LO;
               end
            end
            ST_ADDR_LO: begin
               if (accept_s) begin
                  base_r  <= {addr_hi_r, in_data};
                  idx_r   <= '0;
                  state_r <= ST_CNT_HI;
               end
            end
            ST_CNT_HI: begin
               if (accept_s) begin
                  cnt_hi_r <= in_data;
                  state_r  <= ST_CNT_LO;
               end
            end
            ST_CNT_LO: begin
               if (accept_s) begin
                  cnt_r <= cnt_full_s;
                  if ((cnt_full_s == 16'd0) || ({1'b0, cnt_full_s} > cnt_limit(ADDR_W))) begin
                     state_r    <= ST_ERR;
                     load_err_r <= 1'b1;
                  end else begin
                     state_r <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (word_valid_s) begin
                  mem_we_r    <= 1'b1;
                  mem_addr_r  <= ADDR_W'(base_r + 16'(idx_r));
                  mem_wdata_r <= word_s;
                  idx_r       <= idx_r + IDX_ONE;
                  word_cnt_r  <= word_cnt_r + 16'd1;
                  if (last_word_s) begin
`ifdef LOADER_CKSUM_EN
                     state_r      <= ST_CHECK;
`else
                     state_r      <= ST_START;
                     in_ready_r   <= 1'b0;
                     core_start_r <= 1'b1;
                     core_hold_r  <= 1'b0;
                     load_done_r  <= 1'b1;
`endif
                  end
               end
            end
`ifdef LOADER_CKSUM_EN
            ST_CHECK: begin
               if (accept_s) begin
                  if (in_data == cksum_s) begin
                     state_r      <= ST_START;
                     in_ready_r   <= 1'b0;
                     core_start_r <= 1'b1;
                     core_hold_r  <= 1'b0;
                     load_done_r  <= 1'b1;
                  end else begin
                     state_r    <= ST_ERR;
                     load_err_r <= 1'b1;
                  end
               end
            end
`endif
            ST_START: begin
               state_r     <= ST_RUN;
               run_first_r <= 1'b1;
            end
            // First RUN cycle ignores a HALTED flag left over from the previous program
            ST_RUN: begin
               run_first_r <= 1'b0;
               if (!run_first_r && core_halted) begin
                  core_hold_r <= 1'b1;
                  in_ready_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               core_hold_r <= 1'b1;
               in_ready_r  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed self-checking bench for mips_prog_loader (optionally with LOADER_CKSUM_EN).
module tb_mips_prog_loader;

   localparam int ADDR_W = 10;

   logic              clk1 = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_hold;
   logic              core_start;
   logic              core_halted;
   logic              load_done;
   logic              load_err;
   logic [15:0]       word_cnt;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   int start_cnt = 0;
   int wr_snap;
   int st_snap;
   logic [31:0] words[$];
`ifdef LOADER_CKSUM_EN
   bit bad_ck = 1'b0;
`endif

   always #5 clk1 = ~clk1;

   mips_prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
      .clk1        (clk1),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .core_hold   (core_hold),
      .core_start  (core_start),
      .core_halted (core_halted),
      .load_done   (load_done),
      .load_err    (load_err),
      .word_cnt    (word_cnt)
   );

   always @(posedge clk1) begin
      #1;
      if (mem_we) wr_count++;
      if (core_start) start_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset();
      chk("rst_hold", core_hold, 1);
      chk("rst_ready", in_ready, 1);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_start", core_start, 0);
      chk("rst_done", load_done, 0);
      chk("rst_err", load_err, 0);
      chk("rst_wcnt", word_cnt, 0);
   endtask

   // Called at a negedge; returns at the negedge right after the accepting posedge
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int g;
      int t;
      g = gaps ? $urandom_range(0, 2) : 0;
      in_valid = 1'b0;
      repeat (g) @(negedge clk1);
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk1);
         t++;
      end
      if (!in_ready) chk("ready_timeout", in_ready, 1);
      @(negedge clk1);
      in_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [15:0] base, input logic [15:0] cnt, input bit gaps);
      send_byte(8'hA5, gaps);
      chk("sync_clr_done", load_done, 0);
      chk("sync_clr_err", load_err, 0);
      chk("sync_clr_wcnt", word_cnt, 0);
      send_byte(base[15:8], gaps);
      send_byte(base[7:0], gaps);
      send_byte(cnt[15:8], gaps);
      send_byte(cnt[7:0], gaps);
   endtask

   task automatic send_frame(input logic [15:0] base, input bit gaps);
      logic [7:0]  ck;
      logic [31:0] w;
      ck = 8'd0;
      send_hdr(base, 16'(words.size()), gaps);
      for (int i = 0; i < words.size(); i++) begin
         w = words[i];
         for (int b = 3; b >= 0; b--) begin
            send_byte(w[b*8 +: 8], gaps);
            ck = ck ^ w[b*8 +: 8];
         end
         chk("wr_we", mem_we, 1);
         chk("wr_addr", mem_addr, 32'((32'(base) + 32'(i)) % 1024));
         chk("wr_data", mem_wdata, w);
         chk("wr_wcnt", word_cnt, 32'(i + 1));
      end
`ifdef LOADER_CKSUM_EN
      send_byte(bad_ck ? ~ck : ck, gaps);
`endif
   endtask

   task automatic check_start(input int n);
      chk("st_start", core_start, 1);
      chk("st_hold", core_hold, 0);
      chk("st_ready", in_ready, 0);
      chk("st_done", load_done, 1);
      chk("st_err", load_err, 0);
      chk("st_wcnt", word_cnt, 32'(n));
   endtask

   task automatic run_and_halt(input int cycles);
      @(negedge clk1);
      chk("run_start_low", core_start, 0);
      chk("run_hold", core_hold, 0);
      chk("run_ready", in_ready, 0);
      repeat (cycles) @(negedge clk1);
      chk("run_hold_late", core_hold, 0);
      chk("run_ready_late", in_ready, 0);
      core_halted = 1'b1;
      @(negedge clk1);
      chk("halt_hold", core_hold, 1);
      chk("halt_ready", in_ready, 1);
      chk("halt_done", load_done, 1);
      core_halted = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = 8'd0;
      core_halted = 1'b0;
      repeat (3) @(negedge clk1);
      check_reset();
      rst_n = 1'b1;
      @(negedge clk1);

      // Junk byte in IDLE is swallowed
      send_byte(8'h12, 1'b0);
      chk("idle_junk_hold", core_hold, 1);
      chk("idle_junk_done", load_done, 0);

      // Factorial program, back-to-back bytes
      words = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000,
                32'h14431000, 32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffe,
                32'hfc000000};
      wr_snap = wr_count;
      st_snap = start_cnt;
      send_frame(16'h0000, 1'b0);
      check_start(11);
      run_and_halt(40);
      chk("fact_writes", wr_count - wr_snap, 11);
      chk("fact_starts", start_cnt - st_snap, 1);

      // Second frame while the stale HALTED flag is still high across START
      words = '{32'h00000007};
      core_halted = 1'b1;
      send_frame(16'h00C8, 1'b0);
      check_start(1);
      @(negedge clk1);
      chk("stale_halt_run1", core_hold, 0);
      @(negedge clk1);
      chk("stale_halt_ignored", core_hold, 0);
      core_halted = 1'b0;
      run_and_halt(5);

      // Address wrap
      words = '{32'h11111111, 32'h22222222};
      send_frame(16'h03FF, 1'b0);
      check_start(2);
      run_and_halt(3);

      // Count one past the address space
      wr_snap = wr_count;
      send_hdr(16'h0000, 16'h0401, 1'b0);
      chk("cnt_big_err", load_err, 1);
      chk("cnt_big_hold", core_hold, 1);
      chk("cnt_big_ready", in_ready, 1);
      send_byte(8'h00, 1'b0);
      repeat (2) @(negedge clk1);
      chk("cnt_big_err_sticky", load_err, 1);
      chk("cnt_big_nowr", wr_count - wr_snap, 0);

      // Zero count
      send_hdr(16'h0010, 16'h0000, 1'b0);
      chk("cnt_zero_err", load_err, 1);
      chk("cnt_zero_hold", core_hold, 1);

      // Factorial again with random stalls, from ERR
      words = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000,
                32'h14431000, 32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffe,
                32'hfc000000};
      wr_snap = wr_count;
      send_frame(16'h0000, 1'b1);
      check_start(11);
      in_valid = 1'b1;
      in_data = 8'hA5;
      run_and_halt(10);
      in_valid = 1'b0;
      chk("gap_writes", wr_count - wr_snap, 11);
      chk("gap_state_idle_done", load_done, 1);

`ifdef LOADER_CKSUM_EN
      // Corrupt checksum: memory written, no start
      words = '{32'h00000007};
      st_snap = start_cnt;
      bad_ck = 1'b1;
      send_frame(16'h00C8, 1'b0);
      chk("ck_bad_err", load_err, 1);
      chk("ck_bad_hold", core_hold, 1);
      chk("ck_bad_start", core_start, 0);
      repeat (3) @(negedge clk1);
      chk("ck_bad_nostart", start_cnt - st_snap, 0);
      bad_ck = 1'b0;
      send_frame(16'h00C8, 1'b0);
      check_start(1);
      run_and_halt(2);
`endif

      // Reset in the middle of DATA
      send_hdr(16'h0020, 16'h0002, 1'b0);
      for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + i), 1'b0);
      rst_n = 1'b0;
      @(negedge clk1);
      check_reset();
      rst_n = 1'b1;
      @(negedge clk1);
      words = '{32'hdeadbeef};
      send_frame(16'h0005, 1'b0);
      check_start(1);
      run_and_halt(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
- Upstream feeder for the MIPS32 core: receives a framed byte stream, assembles big-endian 32-bit words, and writes them into core memory through a write port.
- Holds the core halted during loading, then releases it with a start pulse.
- After the core halts, reasserts hold and waits for the next frame.
- Replaces testbench hierarchical preloading of Mem/PC/HALTED with a synthesizable load path.

Parameters:
- ADDR_W, 10, memory word-address width; wraps modulo 2^ADDR_W.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk1  in  1  system clock (core phase-1 clock domain)
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_ready  out  1  byte accepted when in_valid&&in_ready at posedge clk1
- mem_we  out  1  one-cycle memory write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  word data
- core_hold  out  1  1 = core forced halted, PC held at 0
- core_start  out  1  one-cycle pulse; core clears HALTED/TAKEN_BRANCH, PC=0
- core_halted  in  1  core HALTED flag
- load_done  out  1  sticky; set at START, cleared on next sync byte
- load_err  out  1  sticky; set on entry to ERR, cleared on next sync byte
- word_cnt  out  16  words written in current frame

Behaviour:
- Clock and reset: one clock, clk1; reset is synchronous, active-low on rst_n.
- Reset values:
  - State IDLE; core_hold=1, in_ready=1.
  - mem_we=0, mem_addr=0, mem_wdata=0, core_start=0.
  - load_done=0, load_err=0, word_cnt=0.
  - Byte/index counters 0; checksum 0.
- Frame format: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT×4 data bytes (MSB first), then [CKSUM].
- States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CHECK, START, RUN, ERR.
- IDLE: non-sync bytes are accepted and discarded. Sync byte → ADDR_HI, clears load_done/load_err/word_cnt.
- ADDR_LO: base = {hi,lo}[ADDR_W-1:0]; upper bits ignored.
- CNT_LO:
  - CNT==0 → ERR.
  - CNT>2^ADDR_W → ERR.
  - Otherwise → DATA.
- DATA:
  - 2-bit byte counter shifts bytes in.
  - When the 4th byte is accepted, mem_we=1 on the next cycle with mem_addr=(base+idx) mod 2^ADDR_W and mem_wdata=assembled word. Word-write latency: 1 cycle after the 4th byte.
  - idx and word_cnt increment with the write.
  - After word CNT → CHECK (feature on) or START.
- START:
  - in_ready=0.
  - core_start=1 for exactly one cycle; core_hold drops to 0 in the same cycle.
  - load_done=1.
  - → RUN.
- RUN:
  - in_ready=0, core_hold=0.
  - core_halted high while in RUN for ≥1 cycle (the cycle after START is ignored) → core_hold=1 → IDLE.
- ERR:
  - core_hold=1, in_ready=1, load_err=1.
  - Non-sync bytes are discarded; sync byte → ADDR_HI, clearing flags.
- core_hold stays 1 in every state except RUN and the START cycle.
- Stream stalls (in_valid=0) may occur anywhere; state and partial words are held indefinitely, with no timeout.
- A sync byte inside header/data is treated as data; there is no resync.
- Reset asserted mid-frame or mid-RUN: everything returns to reset values next edge; partially written memory is not rolled back.
- Address wrap: base=1023, CNT=2 → writes to 1023 then 0.

Optional Feature:
- Macro: LOADER_CKSUM_EN.
- With the macro:
  - Running XOR of all data bytes (header excluded) is kept.
  - CHECK accepts one byte: equal → START; unequal → ERR with core_hold=1 and no start. Memory is already written.
- Without the macro: CHECK state and checksum logic are absent; DATA → START directly; no trailing byte is expected.

Decomposition:
- Package mips_loader_pkg: state enum, SYNC default, header byte-offset constants, CNT limit function of ADDR_W.
- One sub-module, mips_word_assembler: byte-to-word shift register with 2-bit counter, word_valid pulse, and optional XOR accumulator.
- The FSM stays in the top.

Test Plan:
- Factorial program: frame base 0, CNT 11, words 280a00c8, 28020001, 0e94a000, 21430000, 0e94a000, 14431000, 2c630001, 0e94a000, 3460fffc, 2542fffe, fc000000 (+ correct checksum) → 11 writes at addr 0..10 with matching data, each 1 cycle after its 4th byte; core_start one pulse; word_cnt=11; load_done=1.
- Second frame base 200 (00 C8), CNT 1, data 00000007 → single write addr 200 = 7.
- Wrap: base 03FF, CNT 2 → writes addr 1023 then 0; CNT 0401 → load_err=1, no writes, core_hold=1.
- Random in_valid gaps (50% duty) on the factorial frame → identical write sequence; in_ready=0 in START/RUN.
- With LOADER_CKSUM_EN, corrupt checksum byte → load_err=1, core_start never pulses; next valid frame clears load_err and starts the core.
- core_halted asserted 40 cycles into RUN → core_hold=1 next cycle, state IDLE; rst_n=0 mid-DATA → all outputs at reset values, next frame loads cleanly.
